// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types, constants and small decode helpers for the
//               RV32M multiply/divide unit (muldiv_unit, muldiv_div_step).
// Contents    : muldiv_op_e    - RV32M funct3 encodings
//               muldiv_state_e - controller states
//               MULDIV_ITER, DIV_ZERO_Q, INT_MIN constants
//               op_a_signed / op_b_signed / op_is_div / op_is_quot helpers
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // Division ops that return the quotient (as opposed to the remainder).
  function automatic logic op_is_quot(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_step
// Description : One combinational restoring-division step: shift the next
//               dividend bit into the partial remainder, trial-subtract the
//               divisor, keep the difference if it did not borrow.
// Ports       : rem_i     [31:0] partial remainder (always < divisor_i)
//               dvd_msb_i        next dividend bit, MSB first
//               divisor_i [31:0] divisor magnitude
//               rem_o     [31:0] updated partial remainder
//               q_bit_o          quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step
  import muldiv_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic        dvd_msb_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] w_shifted;
  logic [32:0] w_trial;

  // Because rem_i < divisor_i, the shifted value is below 2*divisor, so a
  // 33-bit subtract suffices: bit 32 of the difference is set exactly when
  // the subtraction borrowed.
  always_comb begin
    w_shifted = {rem_i, dvd_msb_i};
    w_trial   = w_shifted - {1'b0, divisor_i};
    q_bit_o   = ~w_trial[32];
    rem_o     = w_trial[32] ? w_shifted[31:0] : w_trial[31:0];
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Operands are captured
//               on accept and decoded on the following cycle; normal ops then
//               run 32 CALC cycles (shift-add multiply, restoring divide) and
//               present the result for one DONE cycle. Divide-by-zero and
//               signed overflow skip CALC.
// Config      : `define MULDIV_FAST_MUL_EN - multiplies use one combinational
//               product and skip CALC; division is unchanged.
// Ports       : i_clk, i_rst_n       clock, async active-low reset
//               i_valid, i_op[2:0]   request and RV32M funct3
//               i_a, i_b [31:0]      rs1 / rs2, sampled at accept
//               i_flush              abort in-flight operation
//               o_ready              unit can accept (IDLE, nothing pending)
//               o_valid              one-cycle result strobe
//               o_result [31:0]      result, held until replaced
//               o_alu_flags [3:0]    {ovf=0, carry=0, neg, zero}
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [3:0]  o_alu_flags
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  muldiv_state_e state_q, state_d;
  logic          start_q, start_d;   // operands captured, decode pending
  muldiv_op_e    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;       // multiply accumulator
  logic [63:0]   mcand_q, mcand_d;   // extended multiplicand, shifted left
  logic [31:0]   work_q, work_d;     // multiplier (shift right) / dividend->quotient (shift left)
  logic [31:0]   rem_q, rem_d;       // partial remainder
  logic [31:0]   dvsr_q, dvsr_d;     // divisor magnitude
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic [31:0]   result_q, result_d;

  // --------------------------------------------------------------------------
  // Decode of the captured operands
  // --------------------------------------------------------------------------
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;

  assign w_a_neg    = op_a_signed(op_q) & a_q[31];
  assign w_b_neg    = op_b_signed(op_q) & b_q[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag    = w_b_neg ? (32'd0 - b_q) : b_q;
  assign w_div_zero = op_is_div(op_q) && (b_q == 32'd0);
  assign w_div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == INT_MIN) && (b_q == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  // Operands are 33-bit sign/zero-extended values widened to 64 bits; the
  // low 64 bits of the product are exact for any 32x32 RV32M multiply.
  logic signed [63:0] w_fast_a;
  logic signed [63:0] w_fast_b;
  logic signed [63:0] w_fast_prod;

  assign w_fast_a    = {{32{op_a_signed(op_q) & a_q[31]}}, a_q};
  assign w_fast_b    = {{32{op_b_signed(op_q) & b_q[31]}}, b_q};
  assign w_fast_prod = w_fast_a * w_fast_b;
`else
  logic [63:0] w_mcand_init;

  assign w_mcand_init = {{32{op_a_signed(op_q) & a_q[31]}}, a_q};
`endif

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic        w_last;
  logic [63:0] w_addend;
  logic [63:0] w_acc_next;
  logic [31:0] w_rem_next;
  logic        w_q_bit;
  logic [31:0] w_quo_next;
  logic [31:0] w_calc_result;

  assign w_last = (cnt_q == 5'(MULDIV_ITER - 1));

  // For a signed multiplier, bits 32 and 31 of the 33-bit extension are
  // equal, so their combined weight is -2^31: the last step subtracts.
  always_comb begin
    w_addend = '0;
    if (work_q[0]) begin
      w_addend = (w_last && op_b_signed(op_q)) ? (64'd0 - mcand_q) : mcand_q;
    end
  end

  assign w_acc_next = acc_q + w_addend;

  muldiv_div_step u_div_step (
    .rem_i     (rem_q),
    .dvd_msb_i (work_q[31]),
    .divisor_i (dvsr_q),
    .rem_o     (w_rem_next),
    .q_bit_o   (w_q_bit)
  );

  assign w_quo_next = {work_q[30:0], w_q_bit};

  // Result of the final CALC step, with sign correction for division.
  always_comb begin
    w_calc_result = '0;
    if (op_is_div(op_q)) begin
      if (op_is_quot(op_q)) begin
        w_calc_result = q_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
      end else begin
        w_calc_result = r_neg_q ? (32'd0 - w_rem_next) : w_rem_next;
      end
    end else begin
      w_calc_result = (op_q == OP_MUL) ? w_acc_next[31:0] : w_acc_next[63:32];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    work_d   = work_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    if (i_flush) begin
      // Flush wins over everything, including a simultaneous request.
      state_d = ST_IDLE;
      start_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            start_d = 1'b0;
            cnt_d   = '0;
            if (w_div_zero) begin
              result_d = op_is_quot(op_q) ? DIV_ZERO_Q : a_q;
              state_d  = ST_DONE;
            end else if (w_div_ovf) begin
              result_d = (op_q == OP_DIV) ? INT_MIN : 32'd0;
              state_d  = ST_DONE;
            end else if (op_is_div(op_q)) begin
              work_d  = w_a_mag;
              dvsr_d  = w_b_mag;
              rem_d   = '0;
              q_neg_d = w_a_neg ^ w_b_neg;
              r_neg_d = w_a_neg;
              state_d = ST_CALC;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_d = (op_q == OP_MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
              state_d  = ST_DONE;
`else
              mcand_d = w_mcand_init;
              work_d  = b_q;
              acc_d   = '0;
              state_d = ST_CALC;
`endif
            end
          end else if (i_valid) begin
            start_d = 1'b1;
            op_d    = muldiv_op_e'(i_op);
            a_d     = i_a;
            b_d     = i_b;
            cnt_d   = '0;
          end
        end

        ST_CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (op_is_div(op_q)) begin
            work_d = w_quo_next;
            rem_d  = w_rem_next;
          end else begin
            acc_d   = w_acc_next;
            mcand_d = {mcand_q[62:0], 1'b0};
            work_d  = {1'b0, work_q[31:1]};
          end
          if (w_last) begin
            result_d = w_calc_result;
            state_d  = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_ready     = (state_q == ST_IDLE) && !start_q;
  assign o_valid     = (state_q == ST_DONE);
  assign o_result    = result_q;
  assign o_alu_flags = {1'b0, 1'b0, result_q[31], (result_q == 32'd0)};

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic [3:0]  o_alu_flags;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic [5:0] MUL_LAT = 6'd1;
`else
  localparam logic [5:0] MUL_LAT = 6'd33;
`endif
  localparam logic [5:0] DIV_LAT = 6'd33;
  localparam logic [5:0] SPC_LAT = 6'd1;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [5:0]  lat;
  } vec_t;

  muldiv_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_flush     (i_flush),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_result    (o_result),
    .o_alu_flags (o_alu_flags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Issue one operation from a ready state (called #1 after an edge).
  // Returns the edge count from accept to the first o_valid cycle, the
  // result/flags seen then, whether the handshake misbehaved, and o_result
  // one edge later.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic [3:0] flg,
                       output logic hs_bad, output logic [31:0] res_post);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_op = 3'b000; i_a = $urandom; i_b = $urandom;
    lat = 0; hs_bad = 1'b0;
    while (!o_valid && lat < 60) begin
      if (o_ready) hs_bad = 1'b1;
      @(posedge i_clk); #1;
      lat++;
    end
    if (o_ready) hs_bad = 1'b1;
    res = o_result; flg = o_alu_flags;
    @(posedge i_clk); #1;
    if (!o_ready || o_valid) hs_bad = 1'b1;
    res_post = o_result;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", o_result); end
    checks++; if (o_alu_flags !== 4'b0001) begin failures++; $display("FAIL reset_flags: got %b expected 0001", o_alu_flags); end
    repeat (2) @(posedge i_clk);
    #1; i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
  endtask

  task automatic test_mul();
    vec_t v[8];
    int lat; logic [31:0] res, res_post; logic [3:0] flg; logic hs_bad;
    v = '{ {MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0010, MUL_LAT},
           {MUL,    32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 4'b0000, MUL_LAT},
           {MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0010, MUL_LAT},
           {MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 4'b0001, MUL_LAT},
           {MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, MUL_LAT},
           {MULH,   32'h80000000,  32'h80000000, 32'h40000000, 4'b0000, MUL_LAT},
           {MULHSU, 32'h80000000,  32'h80000000, 32'hC0000000, 4'b0010, MUL_LAT},
           {MULHU,  32'h80000000,  32'h00000002, 32'h00000001, 4'b0000, MUL_LAT} };
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, lat, res, flg, hs_bad, res_post);
      checks++; if (lat !== int'(v[i].lat)) begin failures++; $display("FAIL mul[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (res !== v[i].res) begin failures++; $display("FAIL mul[%0d]_result: got %h expected %h", i, res, v[i].res); end
      checks++; if (flg !== v[i].flg) begin failures++; $display("FAIL mul[%0d]_flags: got %b expected %b", i, flg, v[i].flg); end
      checks++; if (hs_bad || res_post !== v[i].res) begin failures++; $display("FAIL mul[%0d]_handshake: got bad=%b held=%h expected bad=0 held=%h", i, hs_bad, res_post, v[i].res); end
    end
  endtask

  task automatic test_div();
    vec_t v[9];
    int lat; logic [31:0] res, res_post; logic [3:0] flg; logic hs_bad;
    v = '{ {DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0010, DIV_LAT},
           {REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0010, DIV_LAT},
           {DIVU, 32'd100,      32'd7,        32'd14,       4'b0000, DIV_LAT},
           {REMU, 32'd100,      32'd7,        32'd2,        4'b0000, DIV_LAT},
           {DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 4'b0010, DIV_LAT},
           {REM,  32'd20,       32'hFFFFFFFD, 32'd2,        4'b0000, DIV_LAT},
           {DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b0010, DIV_LAT},
           {DIVU, 32'd3,        32'd7,        32'd0,        4'b0001, DIV_LAT},
           {DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b0001, DIV_LAT} };
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, lat, res, flg, hs_bad, res_post);
      checks++; if (lat !== int'(v[i].lat)) begin failures++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (res !== v[i].res) begin failures++; $display("FAIL div[%0d]_result: got %h expected %h", i, res, v[i].res); end
      checks++; if (flg !== v[i].flg) begin failures++; $display("FAIL div[%0d]_flags: got %b expected %b", i, flg, v[i].flg); end
      checks++; if (hs_bad || res_post !== v[i].res) begin failures++; $display("FAIL div[%0d]_handshake: got bad=%b held=%h expected bad=0 held=%h", i, hs_bad, res_post, v[i].res); end
    end
  endtask

  task automatic test_div_special();
    vec_t v[6];
    int lat; logic [31:0] res, res_post; logic [3:0] flg; logic hs_bad;
    v = '{ {DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 4'b0010, SPC_LAT},
           {REM,  32'd5,        32'd0,        32'd5,        4'b0000, SPC_LAT},
           {DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0010, SPC_LAT},
           {REMU, 32'd5,        32'd0,        32'd5,        4'b0000, SPC_LAT},
           {DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0010, SPC_LAT},
           {REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b0001, SPC_LAT} };
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, lat, res, flg, hs_bad, res_post);
      checks++; if (lat !== int'(v[i].lat)) begin failures++; $display("FAIL spc[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (res !== v[i].res) begin failures++; $display("FAIL spc[%0d]_result: got %h expected %h", i, res, v[i].res); end
      checks++; if (flg !== v[i].flg) begin failures++; $display("FAIL spc[%0d]_flags: got %b expected %b", i, flg, v[i].flg); end
      checks++; if (hs_bad || res_post !== v[i].res) begin failures++; $display("FAIL spc[%0d]_handshake: got bad=%b held=%h expected bad=0 held=%h", i, hs_bad, res_post, v[i].res); end
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res, res_post; logic [3:0] flg; logic hs_bad; logic seen;
    do_op(DIVU, 32'd100, 32'd7, lat, res, flg, hs_bad, res_post);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL flush_setup: got %h expected 0000000e", res); end
    // Start a DIV and flush it during its tenth cycle.
    i_valid = 1'b1; i_op = DIV; i_a = 32'hFFFFFFF9; i_b = 32'd2;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL flush_idle: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
    checks++; if (o_result !== 32'd14) begin failures++; $display("FAIL flush_result_kept: got %h expected 0000000e", o_result); end
    seen = 1'b0;
    repeat (40) begin @(posedge i_clk); #1; if (o_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_valid: got pulse=%b expected 0", seen); end
    do_op(DIVU, 32'd9, 32'd3, lat, res, flg, hs_bad, res_post);
    checks++; if (res !== 32'd3 || lat !== 33) begin failures++; $display("FAIL flush_followon: got res=%h lat=%0d expected res=00000003 lat=33", res, lat); end
    // Flush together with a request in IDLE: no accept.
    i_valid = 1'b1; i_flush = 1'b1; i_op = DIVU; i_a = 32'd50; i_b = 32'd5;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_priority_ready: got %b expected 1", o_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge i_clk); #1; if (o_valid || !o_ready) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || o_result !== 32'd3) begin failures++; $display("FAIL flush_priority_noop: got activity=%b result=%h expected activity=0 result=00000003", seen, o_result); end
  endtask

  task automatic test_busy_ignore();
    int n; logic seen;
    i_valid = 1'b1; i_op = DIVU; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 60) begin
      if (n == 3) begin i_valid = 1'b1; i_op = DIVU; i_a = 32'd9; i_b = 32'd3; end
      if (n == 8) i_valid = 1'b0;
      @(posedge i_clk); #1;
      n++;
    end
    i_valid = 1'b0;
    checks++; if (n !== 33) begin failures++; $display("FAIL busy_latency: got %0d expected 33", n); end
    checks++; if (o_result !== 32'd14) begin failures++; $display("FAIL busy_result: got %h expected 0000000e", o_result); end
    seen = 1'b0;
    @(posedge i_clk); #1;
    repeat (40) begin if (o_valid || !o_ready) seen = 1'b1; @(posedge i_clk); #1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL busy_no_queue: got activity=%b expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res, res_post; logic [3:0] flg; logic hs_bad;
    i_valid = 1'b1; i_op = MUL; i_a = 32'd7; i_b = 32'hFFFFFFFD;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (14) begin @(posedge i_clk); #1; end
    i_rst_n = 1'b0;
    #2;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
    checks++; if (o_result !== 32'h0 || o_alu_flags !== 4'b0001) begin failures++; $display("FAIL midreset_data: got result=%h flags=%b expected 00000000/0001", o_result, o_alu_flags); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    do_op(DIVU, 32'd9, 32'd3, lat, res, flg, hs_bad, res_post);
    checks++; if (res !== 32'd3 || lat !== 33 || hs_bad) begin failures++; $display("FAIL midreset_recover: got res=%h lat=%0d bad=%b expected 00000003/33/0", res, lat, hs_bad); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_op = 3'b000;
    i_a = 32'h0; i_b = 32'h0; i_flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  rising-edge clock; i_rst_n  in  1  asynchronous active-low reset.
REQ-002 i_valid  in  1  operation request; accepted on a rising edge where i_valid & o_ready.
REQ-003 i_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-004 i_a, i_b  in  32 each  operands rs1, rs2; sampled only at accept.
REQ-005 i_flush  in  1  abort the in-flight operation (pipeline flush).
REQ-006 o_ready  out  1  high only in IDLE; the execute stage stalls while it is low.
REQ-007 o_valid  out  1  one-cycle pulse: o_result is valid.
REQ-008 o_result  out  32  operation result, held from the o_valid cycle until the next accept.
REQ-009 o_alu_flags  out  4  [0] zero, [1] neg (o_result[31]), [2] carry = 0, [3] overflow = 0; same bit layout as the core ALU flags.

Function
REQ-010 FSM states SHALL be IDLE, CALC, DONE: IDLE->CALC on accept; CALC->DONE when the iteration counter reaches 31; DONE->IDLE unconditionally.
REQ-011 Operands SHALL be registered at accept; i_a/i_b changes after accept SHALL have no effect.
REQ-012 Multiply SHALL be radix-2 shift-add on 33-bit sign/zero-extended operands (MULH both signed, MULHSU a signed/b unsigned, MULHU both unsigned), one bit per CALC cycle, 32 CALC cycles; MUL returns the product's low 32 bits, the others the high 32 bits.
REQ-013 Divide SHALL be restoring division on magnitudes, 32 CALC cycles; signed quotient negated when the operand signs differ; signed remainder takes the sign of the dividend.
REQ-014 Latency: for an accept at edge 0, o_valid SHALL be high from edge 33 to edge 34; o_ready SHALL return high at edge 34.
REQ-015 Divide by zero SHALL skip CALC (IDLE->DONE at edge 1): DIV/DIVU return 0xFFFFFFFF; REM/REMU return i_a.
REQ-016 Signed overflow (DIV/REM with i_a=0x80000000, i_b=0xFFFFFFFF) SHALL skip CALC: DIV returns 0x80000000, REM returns 0.
REQ-017 i_flush SHALL force IDLE on the next edge from any state; o_valid SHALL NOT pulse for the aborted operation; o_result SHALL keep its previous value.
REQ-018 i_flush together with i_valid in IDLE SHALL give flush priority: no accept.
REQ-019 i_valid while o_ready is low SHALL be ignored; there is no queueing.
REQ-020 The iteration counter SHALL be 5 bits and SHALL clear on accept and on flush.

Reset
REQ-021 Asynchronous assertion of i_rst_n low SHALL force IDLE, o_ready=1, o_valid=0, o_result=0, counter=0, and all datapath registers to 0, including mid-operation.
REQ-022 o_alu_flags SHALL equal 4'b0001 during reset, since o_result is 0.

Configuration
REQ-023 Macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU SHALL use a single combinational 33x33 multiply and go IDLE->DONE at edge 1, so o_valid is high from edge 1 to edge 2; when undefined, multiply SHALL be iterative per REQ-012/014. Division SHALL be identical in both builds.

Structure
REQ-024 Package muldiv_pkg SHALL hold the muldiv_op_e enum (funct3 encodings), the muldiv_state_e enum, and the constants MULDIV_ITER = 32, DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
REQ-025 Sub-module muldiv_div_step (one combinational restoring-division step: remainder shift, trial subtract, quotient bit) SHALL be instantiated once; everything else SHALL be in muldiv_unit.

Verification
REQ-026 MUL a=7, b=-3 (0xFFFFFFFD) -> o_result 0xFFFFFFEB, flags 0010, o_valid at edge 33 (edge 1 with MULDIV_FAST_MUL_EN).
REQ-027 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000, flags 0001; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with o_valid at edge 33.
REQ-029 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; each with o_valid at edge 1.
REQ-030 Assert i_flush at cycle 10 of a DIV -> no o_valid pulse, o_ready=1 after the next edge, o_result unchanged; an immediate follow-on DIVU 9/3 -> 3.
REQ-031 Drop i_rst_n at cycle 15 of a MUL -> o_ready=1, o_valid=0, o_result=0 at once; i_valid asserted during CALC is ignored.
